// File: rtl/cp_fifo_pkg.sv
// Shared definitions for the cp_fifo family: default sizes, read-mode encodings
// and the threshold legality check used at elaboration.
package cp_fifo_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 4;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Thresholds must satisfy 0 <= AE_THR < AF_THR <= DEPTH, with AF_THR >= 1.
    function automatic bit thr_legal(input int addr_w, input int af_thr, input int ae_thr);
        return (ae_thr >= 0) && (af_thr >= 1) && (ae_thr < af_thr) &&
               (af_thr <= (1 << addr_w));
    endfunction

endpackage

// File: rtl/cp_fifo_if.sv
// Producer/consumer bundle for cp_fifo. The FIFO side uses the slave modport;
// the stage driving requests uses the master modport.
interface cp_fifo_if
    import cp_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) ();

    // Handshake: wr is accepted when the FIFO is not full or a read is accepted in
    // the same cycle; rd is accepted when not empty. clear overrides both.
    logic              clear;
    logic              wr;
    logic [DATA_W-1:0] din;
    logic              rd;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              empty;
    logic              full;
    logic              almost_empty;
    logic              almost_full;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;

    modport master (
        output clear, wr, din, rd,
        input  dout, dout_valid, empty, full, almost_empty, almost_full,
               count, overflow, underflow
    );

    modport slave (
        input  clear, wr, din, rd,
        output dout, dout_valid, empty, full, almost_empty, almost_full,
               count, overflow, underflow
    );

endinterface

// File: rtl/cp_fifo_mem.sv
// Simple dual-port storage for cp_fifo: one synchronous write port, one read port
// that is registered in standard mode and combinational in FWFT mode.
module cp_fifo_mem
    import cp_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int FWFT   = FIFO_MODE_STD
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
    end

    generate
        if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
            wire unused_ok = &{1'b0, re, reset_n};
            assign rdata = mem[raddr];
        end else begin : g_std
            logic [DATA_W-1:0] rdata_q;
            // Output register holds its value between reads, including across clear.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n)  rdata_q <= '0;
                else if (re)   rdata_q <= mem[raddr];
            end
            assign rdata = rdata_q;
        end
    endgenerate

endmodule

// File: rtl/cp_fifo.sv
// Single-clock FIFO using the full 2**ADDR_W depth, with exact occupancy count,
// registered threshold flags, sticky error flags, flush and selectable FWFT reads.
module cp_fifo
    import cp_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int AF_THR = (1 << ADDR_W) - 2,
    parameter int AE_THR = 2,
    parameter int FWFT   = FIFO_MODE_STD
) (
    input logic     clock,
    input logic     reset_n,
    cp_fifo_if.slave bus
);

    localparam int              DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_THR);
    localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_THR);
    localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

    generate
        if (!thr_legal(ADDR_W, AF_THR, AE_THR)) begin : g_bad_params
            $error("cp_fifo: thresholds must satisfy AE_THR < AF_THR <= DEPTH");
        end
    endgenerate

    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   count_q, count_n;
    logic              empty_q, full_q, ae_q, af_q, ovf_q, udf_q;
    logic              rd_acc, wr_acc;
    logic [DATA_W-1:0] mem_rdata;

    // clear masks both accepts so nothing is written, popped or flagged that cycle.
    always_comb begin
        rd_acc  = bus.rd & ~empty_q & ~bus.clear;
        wr_acc  = bus.wr & (~full_q | rd_acc) & ~bus.clear;
        count_n = count_q;
        if (bus.clear)               count_n = '0;
        else if (wr_acc && !rd_acc)  count_n = count_q + ONE_C;
        else if (rd_acc && !wr_acc)  count_n = count_q - ONE_C;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ae_q    <= 1'b1;
            af_q    <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            if (bus.clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                ovf_q  <= 1'b0;
                udf_q  <= 1'b0;
            end else begin
                if (wr_acc)               wr_ptr <= wr_ptr + ADDR_W'(1);
                if (rd_acc)               rd_ptr <= rd_ptr + ADDR_W'(1);
                if (bus.wr && !wr_acc)    ovf_q  <= 1'b1;
                if (bus.rd && !rd_acc)    udf_q  <= 1'b1;
            end
            // Flags decode the next count so they never lag it.
            count_q <= count_n;
            empty_q <= (count_n == '0);
            full_q  <= (count_n == DEPTH_C);
            ae_q    <= (count_n <= AE_C);
            af_q    <= (count_n >= AF_C);
        end
    end

    cp_fifo_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .FWFT   (FWFT)
    ) u_mem (
        .clock   (clock),
        .reset_n (reset_n),
        .we      (wr_acc),
        .waddr   (wr_ptr),
        .wdata   (bus.din),
        .re      (rd_acc),
        .raddr   (rd_ptr),
        .rdata   (mem_rdata)
    );

    generate
        if (FWFT == FIFO_MODE_FWFT) begin : g_out_fwft
            // Memory contents survive reset/clear, so mask the head word when empty.
            assign bus.dout       = empty_q ? '0 : mem_rdata;
            assign bus.dout_valid = ~empty_q;
        end else begin : g_out_std
            logic dout_valid_q;
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) dout_valid_q <= 1'b0;
                else          dout_valid_q <= rd_acc;
            end
            assign bus.dout       = mem_rdata;
            assign bus.dout_valid = dout_valid_q;
        end
    endgenerate

    assign bus.count        = count_q;
    assign bus.empty        = empty_q;
    assign bus.full         = full_q;
    assign bus.almost_empty = ae_q;
    assign bus.almost_full  = af_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;

endmodule
